quiz_round_controller: RTL

Sequencer and buzzer arbiter for the quiz display path. It accepts contestant buzzers, grants exactly one answering contestant per round, times the answer window and takes the quizmaster's verdict. It then selects which screen image (question / wrong / correct) the LT24 picture multiplexer shows, with screen changes applied only at frame boundaries. It sits between the board keys and the display top level, replacing ad-hoc answered/correct inputs with a clean screen select.

---
 rtl/quiz_pkg.sv | 28 ++
 rtl/quiz_round_controller_if.sv | 31 +++
 rtl/quiz_round_controller_buzz_sync_edge.sv | 42 ++++
 rtl/quiz_round_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz round controller.
// Holds the round state encoding, the screen-select codes driven towards
// the LT24 picture multiplexer, the default timing constants and a helper
// for sizing cycle counters.
package quiz_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_RESULT = 2'd3
   } round_state_t;

   localparam logic [1:0] SCREEN_QUESTION = 2'd0;
   localparam logic [1:0] SCREEN_WRONG    = 2'd1;
   localparam logic [1:0] SCREEN_CORRECT  = 2'd2;

   localparam int DEFAULT_NUM_PLAYERS   = 4;
   localparam int DEFAULT_ANSWER_CYCLES = 500000000;  // 10 s at 50 MHz
   localparam int DEFAULT_RESULT_CYCLES = 150000000;  // 3 s at 50 MHz
   localparam int DEFAULT_SCORE_W       = 4;

   // Counter width for a window of 'cycles' clocks; never narrower than one bit.
   function automatic int timer_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/quiz_round_controller_if.sv
// Key/display bundle of the quiz round controller.
//   startRound, buzz, judgeCorrect, judgeWrong, frameDone : towards controller
//   screenSel, winnerId, winnerValid, timedOut, scores    : from controller
// master = board keys / display side, slave = the controller.
interface quiz_round_controller_if
   import quiz_pkg::*;
#(
   parameter int NUM_PLAYERS = DEFAULT_NUM_PLAYERS,
   parameter int SCORE_W     = DEFAULT_SCORE_W
);
   logic                           startRound;
   logic [NUM_PLAYERS-1:0]         buzz;
   logic                           judgeCorrect;
   logic                           judgeWrong;
   logic                           frameDone;
   logic [1:0]                     screenSel;
   logic [2:0]                     winnerId;
   logic                           winnerValid;
   logic                           timedOut;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores;

   modport master (
      output startRound, buzz, judgeCorrect, judgeWrong, frameDone,
      input  screenSel, winnerId, winnerValid, timedOut, scores
   );

   modport slave (
      input  startRound, buzz, judgeCorrect, judgeWrong, frameDone,
      output screenSel, winnerId, winnerValid, timedOut, scores
   );
endinterface

// File: rtl/quiz_round_controller_buzz_sync_edge.sv
// buzz_sync_edge: per-bit two-flop synchroniser followed by a registered
// rising-edge detector for the contestant buttons.
//   clock, globalReset : clock and asynchronous active-high reset
//   async_in[WIDTH]    : raw asynchronous button levels
//   rise[WIDTH]        : one-cycle pulse per synchronised 0->1 transition
// A button rising at edge N produces a rise pulse after edge N+2.
module buzz_sync_edge #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             globalReset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] rise
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;
         logic sync_d_reg;
         logic rise_reg;

         always_ff @(posedge clock or posedge globalReset) begin
            if (globalReset) begin
               meta_reg   <= 1'b0;
               sync_reg   <= 1'b0;
               sync_d_reg <= 1'b0;
               rise_reg   <= 1'b0;
            end else begin
               meta_reg   <= async_in[gi];
               sync_reg   <= meta_reg;
               sync_d_reg <= sync_reg;
               rise_reg   <= sync_reg & ~sync_d_reg;
            end
         end

         assign rise[gi] = rise_reg;
      end
   endgenerate

endmodule

// File: rtl/quiz_round_controller.sv
// quiz_round_controller: buzzer arbiter and round sequencer for the quiz
// display path. Grants one contestant per round with rotating priority,
// times the answer window, applies the verdict to the scores and selects
// the screen image, changing it only on frame boundaries.
//   clock       : system clock
//   globalReset : asynchronous active-high reset
//   bus         : slave side of quiz_round_controller_if (keys in, display out)
module quiz_round_controller
   import quiz_pkg::*;
#(
   parameter int NUM_PLAYERS   = DEFAULT_NUM_PLAYERS,
   parameter int ANSWER_CYCLES = DEFAULT_ANSWER_CYCLES,
   parameter int RESULT_CYCLES = DEFAULT_RESULT_CYCLES,
   parameter int SCORE_W       = DEFAULT_SCORE_W
) (
   input  logic                    clock,
   input  logic                    globalReset,
   quiz_round_controller_if.slave  bus
);

   localparam int AT_W = timer_width(ANSWER_CYCLES);
   localparam int RT_W = timer_width(RESULT_CYCLES);
   localparam logic [AT_W-1:0]    AT_LAST   = AT_W'(ANSWER_CYCLES - 1);
   localparam logic [RT_W-1:0]    RT_LAST   = RT_W'(RESULT_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   round_state_t           state_reg, state_next;
   logic [NUM_PLAYERS-1:0] lockout_reg, lockout_next;
   logic [2:0]             winner_id_reg, winner_id_next;
   logic [2:0]             last_winner_reg, last_winner_next;
   logic [AT_W-1:0]        answer_timer_reg;
   logic [RT_W-1:0]        result_timer_reg;
   logic [1:0]             screen_req_reg, screen_req_next;
   logic [1:0]             screen_sel_reg;
   logic                   timed_out_reg;
   logic                   timeout_pulse;
   logic                   verdict_correct;
   logic                   score_inc;

   logic [NUM_PLAYERS-1:0] buzz_rise;
   logic [NUM_PLAYERS-1:0] eligible;
   logic                   grant_any;
   logic [2:0]             grant_id;

   buzz_sync_edge #(.WIDTH(NUM_PLAYERS)) u_buzz_sync_edge (
      .clock       (clock),
      .globalReset (globalReset),
      .async_in    (bus.buzz),
      .rise        (buzz_rise)
   );

   assign eligible = buzz_rise & ~lockout_reg;

   // Rotating priority: the search begins just after the previous winner.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_id  = 3'd0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         idx = (int'(last_winner_reg) + 1 + i) % NUM_PLAYERS;
         if (!grant_any && eligible[idx]) begin
            grant_any = 1'b1;
            grant_id  = 3'(idx);
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      lockout_next     = lockout_reg;
      winner_id_next   = winner_id_reg;
      last_winner_next = last_winner_reg;
      timeout_pulse    = 1'b0;
      verdict_correct  = 1'b0;
      score_inc        = 1'b0;
      screen_req_next  = screen_req_reg;

      case (state_reg)
         ST_IDLE: begin
            // Edges before the round is armed are false starts.
            lockout_next = lockout_reg | buzz_rise;
            if (bus.startRound) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (grant_any) begin
               state_next       = ST_LOCKED;
               winner_id_next   = grant_id;
               last_winner_next = grant_id;
            end
         end
         ST_LOCKED: begin
            // A verdict on the final count beats the timeout.
            if (bus.judgeCorrect) begin
               state_next      = ST_RESULT;
               verdict_correct = 1'b1;
               score_inc       = 1'b1;
            end else if (bus.judgeWrong) begin
               state_next = ST_RESULT;
            end else if (answer_timer_reg == AT_LAST) begin
               state_next    = ST_RESULT;
               timeout_pulse = 1'b1;
            end
         end
         ST_RESULT: begin
            if (result_timer_reg == RT_LAST) begin
               state_next   = ST_IDLE;
               lockout_next = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (state_next != state_reg) begin
         if (state_next == ST_RESULT)
            screen_req_next = verdict_correct ? SCREEN_CORRECT : SCREEN_WRONG;
         else
            screen_req_next = SCREEN_QUESTION;
      end
   end

   always_ff @(posedge clock or posedge globalReset) begin
      if (globalReset) begin
         state_reg        <= ST_IDLE;
         lockout_reg      <= '0;
         winner_id_reg    <= 3'd0;
         last_winner_reg  <= 3'(NUM_PLAYERS - 1);
         answer_timer_reg <= '0;
         result_timer_reg <= '0;
         screen_req_reg   <= SCREEN_QUESTION;
         screen_sel_reg   <= SCREEN_QUESTION;
         timed_out_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         lockout_reg     <= lockout_next;
         winner_id_reg   <= winner_id_next;
         last_winner_reg <= last_winner_next;
         screen_req_reg  <= screen_req_next;
         timed_out_reg   <= timeout_pulse;
         // Timers count only while their state persists and clear on exit.
         answer_timer_reg <= (state_reg == ST_LOCKED && state_next == ST_LOCKED)
                             ? answer_timer_reg + 1'b1 : '0;
         result_timer_reg <= (state_reg == ST_RESULT && state_next == ST_RESULT)
                             ? result_timer_reg + 1'b1 : '0;
         if (bus.frameDone) screen_sel_reg <= screen_req_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
         logic [SCORE_W-1:0] score_reg;

         always_ff @(posedge clock or posedge globalReset) begin
            if (globalReset)
               score_reg <= '0;
            else if (score_inc && winner_id_reg == 3'(gi) && score_reg != SCORE_MAX)
               score_reg <= score_reg + 1'b1;
         end

         assign bus.scores[gi*SCORE_W +: SCORE_W] = score_reg;
      end
   endgenerate

   assign bus.screenSel   = screen_sel_reg;
   assign bus.winnerId    = winner_id_reg;
   assign bus.winnerValid = (state_reg == ST_LOCKED) || (state_reg == ST_RESULT);
   assign bus.timedOut    = timed_out_reg;

endmodule
